// File: rtl/bp_me_nonsynth_pkg.sv
// bp_me_nonsynth_pkg
//   Shared types and helpers for the non-synthesizable ME mock memory.
//   - bp_me_nonsynth_mem_op_e : command opcodes understood by the responder
//   - bp_me_nonsynth_state_e  : responder FSM states
//   - size_to_bytes()         : log2 size field -> byte count
//   - cmd_legal()             : opcode/size legality check
package bp_me_nonsynth_pkg;

  typedef enum logic [2:0] {
    e_mem_rd    = 3'd0,
    e_mem_wr    = 3'd1,
    e_mem_uc_rd = 3'd2,
    e_mem_uc_wr = 3'd3
  } bp_me_nonsynth_mem_op_e;

  typedef enum logic [1:0] {
    e_state_idle = 2'd0,
    e_state_wait = 2'd1,
    e_state_push = 2'd2
  } bp_me_nonsynth_state_e;

  // Largest legal log2 access size: one full 64 B block.
  localparam logic [2:0] max_size_lp = 3'd6;

  // Byte count for a log2 size field; 8 bits so size 7 does not wrap to 0.
  function automatic logic [7:0] size_to_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

  function automatic logic cmd_legal(input logic [2:0] opcode, input logic [2:0] size);
    return (opcode <= e_mem_uc_wr) && (size <= max_size_lp);
  endfunction

endpackage

// File: rtl/bp_me_nonsynth_mem_resp_queue.sv
// bp_me_nonsynth_mem_resp_queue
//   In-order response FIFO for the mock memory responder.
//   Ports:
//     clk_i, reset_n_i   clock, asynchronous active-low reset
//     v_i, data_i        enqueue strobe and packed response
//     v_o, data_o        head entry valid and contents
//     yumi_i             head consumed (only legal while v_o is high)
//     occupancy_o        number of entries currently held
module bp_me_nonsynth_mem_resp_queue #(
  parameter int els_p   = 4,
  parameter int width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   occupancy_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

  logic [width_p-1:0]      mem [els_p];
  logic [ptr_width_lp-1:0] head_reg, tail_reg;
  logic [cnt_width_lp-1:0] count_reg;
  logic                    enq, deq;

  assign enq = v_i;
  assign deq = yumi_i & v_o;

  assign v_o         = (count_reg != '0);
  assign data_o      = mem[head_reg];
  assign occupancy_o = count_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) tail_reg <= (tail_reg == last_ptr_lp) ? '0 : tail_reg + 1'b1;
      if (deq) head_reg <= (head_reg == last_ptr_lp) ? '0 : head_reg + 1'b1;
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (enq) mem[tail_reg] <= data_i;
  end

  // Consuming from an empty queue is a bench bug.
  assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
  // A push into a full queue is only tolerable when the head leaves the same cycle.
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   v_i |-> ((count_reg < cnt_width_lp'(els_p)) || yumi_i));

endmodule

// File: rtl/bp_me_nonsynth_mem_responder.sv
// bp_me_nonsynth_mem_responder
//   Mock cache-block memory for ME benches. Accepts one CCE memory command at
//   a time, waits latency_p cycles, performs the backing-store access and
//   queues an in-order response.
//   Ports:
//     clk_i, reset_n_i             clock, asynchronous active-low reset
//     cmd_v_i / cmd_ready_o        command valid-ready handshake
//     cmd_opcode_i/addr/size/payload/data_i   command fields (sampled on accept)
//     resp_v_o / resp_yumi_i       response valid / consumed
//     resp_opcode/addr/size/payload_o         echoed command header
//     resp_data_o                  read data, zero for writes and errors
//     error_o                      sticky illegal opcode/size flag
module bp_me_nonsynth_mem_responder
  import bp_me_nonsynth_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  parameter int mem_els_p       = 256,
  parameter int latency_p       = 4,
  parameter int resp_els_p      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,
  input  logic [2:0]                 cmd_opcode_i,
  input  logic [paddr_width_p-1:0]   cmd_addr_i,
  input  logic [2:0]                 cmd_size_i,
  input  logic [payload_width_p-1:0] cmd_payload_i,
  input  logic [block_width_p-1:0]   cmd_data_i,
  output logic                       resp_v_o,
  input  logic                       resp_yumi_i,
  output logic [2:0]                 resp_opcode_o,
  output logic [paddr_width_p-1:0]   resp_addr_o,
  output logic [2:0]                 resp_size_o,
  output logic [payload_width_p-1:0] resp_payload_o,
  output logic [block_width_p-1:0]   resp_data_o,
  output logic                       error_o
);

  localparam int block_bytes_lp  = block_width_p / 8;
  localparam int offset_width_lp = $clog2(block_bytes_lp);
  localparam int index_width_lp  = $clog2(mem_els_p);
  localparam int cnt_width_lp    = $clog2(latency_p + 1);
  localparam int occ_width_lp    = $clog2(resp_els_p + 1);
  localparam int resp_width_lp   = 3 + paddr_width_p + 3 + payload_width_p + block_width_p;

  logic [block_width_p-1:0] mem [mem_els_p];

  bp_me_nonsynth_state_e        state_reg;
  logic [cnt_width_lp-1:0]      cnt_reg;
  logic                         error_reg;
  logic [2:0]                   opcode_reg;
  logic [paddr_width_p-1:0]     addr_reg;
  logic [2:0]                   size_reg;
  logic [payload_width_p-1:0]   payload_reg;
  logic [block_width_p-1:0]     data_reg;

  logic [occ_width_lp-1:0]      resp_occupancy;
  logic                         cmd_accept;
  logic                         cmd_ok;
  logic [index_width_lp-1:0]    index;
  logic [offset_width_lp-1:0]   offset;
  logic [offset_width_lp-1:0]   byte_mask;
  logic [offset_width_lp-1:0]   aligned_offset;
  logic [block_width_p-1:0]     mem_block;
  logic [block_width_p-1:0]     uc_rd_data;
  logic [block_width_p-1:0]     uc_wr_block;
  logic [block_width_p-1:0]     resp_data_next;
  logic                         push;
  logic [resp_width_lp-1:0]     resp_packed;

  // Only IDLE accepts, and only one command is ever in flight, so a free slot
  // seen in IDLE is guaranteed to still be free when that command pushes.
  assign cmd_ready_o = reset_n_i & (state_reg == e_state_idle)
                     & (resp_occupancy < occ_width_lp'(resp_els_p));
  assign cmd_accept  = cmd_v_i & cmd_ready_o;
  assign error_o     = error_reg;
  assign push        = (state_reg == e_state_push);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= e_state_idle;
      cnt_reg   <= '0;
      error_reg <= 1'b0;
    end else begin
      case (state_reg)
        e_state_idle: begin
          if (cmd_accept) begin
            cnt_reg   <= cnt_width_lp'(latency_p - 1);
            state_reg <= (latency_p == 1) ? e_state_push : e_state_wait;
            if (!cmd_legal(cmd_opcode_i, cmd_size_i)) error_reg <= 1'b1;
          end
        end
        e_state_wait: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == cnt_width_lp'(1)) state_reg <= e_state_push;
        end
        e_state_push: state_reg <= e_state_idle;
        default:      state_reg <= e_state_idle;
      endcase
    end
  end

  // Command fields are captured on accept so the sender may change them afterwards.
  always_ff @(posedge clk_i) begin
    if (cmd_accept) begin
      opcode_reg  <= cmd_opcode_i;
      addr_reg    <= cmd_addr_i;
      size_reg    <= cmd_size_i;
      payload_reg <= cmd_payload_i;
      data_reg    <= cmd_data_i;
    end
  end

  // Upper address bits are dropped, so addresses alias across the store.
  assign index          = addr_reg[offset_width_lp +: index_width_lp];
  assign offset         = addr_reg[offset_width_lp-1:0];
  assign cmd_ok         = cmd_legal(opcode_reg, size_reg);
  assign byte_mask      = offset_width_lp'(size_to_bytes(size_reg) - 8'd1);
  assign aligned_offset = offset & ~byte_mask;
  assign mem_block      = mem[index];

  // Per byte lane: uncached reads replicate the aligned window across the
  // block; uncached writes merge low-order command bytes into that window.
  for (genvar gi = 0; gi < block_bytes_lp; gi++) begin : g_lane
    logic [offset_width_lp-1:0] lane_id;
    logic [offset_width_lp-1:0] rd_sel;
    logic [offset_width_lp-1:0] wr_src;
    logic                       wr_hit;

    assign lane_id = offset_width_lp'(gi);
    assign rd_sel  = aligned_offset | (lane_id & byte_mask);
    assign wr_src  = lane_id & byte_mask;
    assign wr_hit  = ((lane_id & ~byte_mask) == aligned_offset);

    assign uc_rd_data[8*gi +: 8]  = mem_block[{rd_sel, 3'b000} +: 8];
    assign uc_wr_block[8*gi +: 8] = wr_hit ? data_reg[{wr_src, 3'b000} +: 8]
                                           : mem_block[8*gi +: 8];
  end

  always_comb begin
    resp_data_next = '0;
    if (cmd_ok) begin
      case (opcode_reg)
        e_mem_rd:    resp_data_next = mem_block;
        e_mem_uc_rd: resp_data_next = uc_rd_data;
        default:     resp_data_next = '0;
      endcase
    end
  end

  // The store is deliberately outside the reset domain: it survives reset.
  always_ff @(posedge clk_i) begin
    if (push && cmd_ok) begin
      case (opcode_reg)
        e_mem_wr:    mem[index] <= data_reg;
        e_mem_uc_wr: mem[index] <= uc_wr_block;
        default:     ;
      endcase
    end
  end

  bp_me_nonsynth_mem_resp_queue #(
    .els_p   (resp_els_p),
    .width_p (resp_width_lp)
  ) resp_queue (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (push),
    .data_i      ({opcode_reg, addr_reg, size_reg, payload_reg, resp_data_next}),
    .v_o         (resp_v_o),
    .data_o      (resp_packed),
    .yumi_i      (resp_yumi_i),
    .occupancy_o (resp_occupancy)
  );

  assign {resp_opcode_o, resp_addr_o, resp_size_o, resp_payload_o, resp_data_o} = resp_packed;

endmodule

// File: doc/bp_me_nonsynth_mem_responder.md
Name: bp_me_nonsynth_mem_responder

Overview:
- Nonsynthesizable mock memory for ME unit benches. It answers the cache-block memory commands a CCE issues and returns in-order responses after a fixed, configurable latency.
- Sits on the CCE memory command/response interface in place of bp_mem. Gives a deterministic, DRAM-free responder that stalls through a bounded response queue.

Parameters:
- paddr_width_p, 40, physical address width
- block_width_p, 512, cache block width in bits (64 B)
- payload_width_p, 16, opaque header payload (lce id, way, state), echoed unchanged
- mem_els_p, 256, number of blocks in backing store
- latency_p, 4, cycles from command accept to response enqueue (must be >= 1)
- resp_els_p, 4, response queue depth (must be >= 2)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous, active-low
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  command ready (valid-ready handshake)
- cmd_opcode_i  in  3  0=rd, 1=wr, 2=uc_rd, 3=uc_wr, others illegal
- cmd_addr_i  in  paddr_width_p  byte address
- cmd_size_i  in  3  log2 bytes, 0..6
- cmd_payload_i  in  payload_width_p  opaque payload
- cmd_data_i  in  block_width_p  write data
- resp_v_o  out  1  response valid
- resp_yumi_i  in  1  response consumed (asserted only when resp_v_o is high)
- resp_opcode_o  out  3  echo of cmd opcode
- resp_addr_o  out  paddr_width_p  echo of cmd addr
- resp_size_o  out  3  echo of cmd size
- resp_payload_o  out  payload_width_p  echo of cmd payload
- resp_data_o  out  block_width_p  read data; zero for writes
- error_o  out  1  sticky; set on an illegal opcode or size > 6

Behaviour:
- Reset (async assert, sync deassert):
  - cmd_ready_o=0, resp_v_o=0, error_o=0.
  - FSM goes to IDLE, counter=0, queue empty, any in-flight command dropped.
  - Backing store is not cleared; it is zero at time 0.
- Index: addr[6 +: log2(mem_els_p)]. Upper address bits are ignored, so addresses alias.
- FSM states IDLE, WAIT, PUSH:
  - IDLE: cmd_ready_o = (occupancy + 0) < resp_els_p. On cmd_v_i&cmd_ready_o, latch all command fields and load counter=latency_p-1. Go to PUSH if latency_p==1, else WAIT.
  - WAIT: decrement the counter. At 1, go to PUSH.
  - PUSH: perform the store access, enqueue the response, return to IDLE. cmd_ready_o=0 in WAIT and PUSH.
- Latency: accept at cycle t gives resp_v_o at t+latency_p when the queue is empty. Throughput is one command per latency_p+1 cycles.
- Access rules:
  - rd: the full block is returned. Address offset bits are ignored for indexing but echoed.
  - wr: the full block is written.
  - uc_rd: 2^size bytes are read at addr[5:0] aligned down to size, then replicated across block_width_p.
  - uc_wr: 2^size bytes are taken from cmd_data_i[0 +: 8*2^size] and written at that aligned offset. Other bytes are unchanged.
  - Illegal opcode or size: error_o set, no store access, response returned with data 0.
- Ordering: writes are visible to every later-accepted command. Responses are returned strictly in acceptance order.
- Queue:
  - Simultaneous enqueue and dequeue is legal when full or empty.
  - Full queue: IDLE holds cmd_ready_o=0, so no command is accepted without a free slot.
  - resp_yumi_i without resp_v_o is a bench error; a non-synth assertion fires.
- The cmd_*_i fields need only be stable on the accept cycle.

Decomposition:
- Shared package bp_me_nonsynth_pkg gets:
  - the mem responder opcode enum (rd/wr/uc_rd/uc_wr)
  - the size-to-bytes function
  - the FSM state enum
- Sub-module bp_me_nonsynth_mem_resp_queue holds the response FIFO: resp_els_p entries of {opcode, addr, size, payload, data}, valid/yumi output, occupancy output. It uses the same async active-low reset.

Test Plan:
- wr addr 0x80 data all 0xA5, then rd addr 0x80 at latency_p=4 -> wr response at t+4 with data 0; rd response returns all-0xA5; payloads echoed.
- uc_wr addr 0x84 size 2 data 0xDEADBEEF, then uc_rd addr 0x84 size 2 -> read data 0xDEADBEEF replicated 16 times; block rd 0x80 shows only bytes 4..7 changed.
- Hold resp_yumi_i=0, issue 5 rd commands with resp_els_p=4 -> 4 accepted, then cmd_ready_o=0 until the first yumi. All 5 returned in order.
- Assert reset_n_i low mid-WAIT -> resp_v_o, cmd_ready_o drop immediately, no response emitted; prior wr data still readable after reset.
- Opcode 5 -> error_o=1 sticky, response with data 0 after latency_p; a subsequent legal command works normally.
- Alias check with mem_els_p=256: wr 0x0 then rd 0x4000 -> same data returned.
